// File: rtl/ft_pkg.sv
// Shared types and default tuning values for the TMR voter/monitor.
// Optional stats counters: define FT_ERR_STATS_EN.
package ft_pkg;

  typedef enum logic [1:0] {
    FT_OK        = 2'd0,
    FT_BROKEN    = 2'd1,
    FT_PROBATION = 2'd2
  } ft_rep_state_e;

  localparam int unsigned FTVM_NUM_CH    = 3;
  localparam int unsigned FTVM_W         = 32;
  localparam int unsigned FTVM_LATENCY   = 0;
  localparam int unsigned FTVM_COUNT_BIT = 4;
  localparam int unsigned FTVM_INCREMENT = 3;
  localparam int unsigned FTVM_DECREMENT = 1;
  localparam int unsigned FTVM_THRESHOLD = 8;
  localparam int unsigned FTVM_RECOVER   = 1;
  localparam int unsigned FTVM_HOLDOFF   = 64;
  localparam int unsigned FTVM_PROBE_LEN = 16;
  localparam int unsigned FTVM_STAT_W    = 16;

  function automatic logic [1:0] ft_popcnt3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/cv32e40p_ft_replica_monitor.sv
// Per-replica health FSM: leaky error counter, holdoff and probation.
// Optional per-replica error statistics: define FT_ERR_STATS_EN.
module cv32e40p_ft_replica_monitor
  import ft_pkg::*;
#(
  parameter int unsigned COUNT_BIT = FTVM_COUNT_BIT,
  parameter int unsigned INCREMENT = FTVM_INCREMENT,
  parameter int unsigned DECREMENT = FTVM_DECREMENT,
  parameter int unsigned THRESHOLD = FTVM_THRESHOLD,
  parameter int unsigned RECOVER   = FTVM_RECOVER,
  parameter int unsigned HOLDOFF   = FTVM_HOLDOFF,
  parameter int unsigned PROBE_LEN = FTVM_PROBE_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        err_i,
  input  logic        set_broken_i,
  input  logic        clr_stats_i,
  output logic [1:0]  state_o,
  output logic [15:0] err_count_o
);

  localparam int unsigned TW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam int unsigned PW = (PROBE_LEN > 1) ? $clog2(PROBE_LEN) : 1;
  localparam int unsigned CW = COUNT_BIT + 1;

  localparam logic [CW-1:0] CMAX = {1'b0, {COUNT_BIT{1'b1}}};
  localparam logic [CW-1:0] INC  = CW'(INCREMENT);
  localparam logic [CW-1:0] DEC  = CW'(DECREMENT);
  localparam logic [CW-1:0] THR  = CW'(THRESHOLD);
  localparam logic [TW-1:0] T_LAST = TW'(HOLDOFF - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PROBE_LEN - 1);

  ft_rep_state_e state_q, state_d;
  logic [COUNT_BIT-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [PW-1:0] probe_q, probe_d;
  logic [CW-1:0] cnt_up, cnt_dn, cnt_nx;

  // One extra bit so the add can saturate instead of wrapping.
  always_comb begin
    cnt_up = {1'b0, cnt_q} + INC;
    if (cnt_up > CMAX) cnt_up = CMAX;
    cnt_dn = '0;
    if ({1'b0, cnt_q} >= DEC) cnt_dn = {1'b0, cnt_q} - DEC;
    cnt_nx = err_i ? cnt_up : cnt_dn;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    timer_d = timer_q;
    probe_d = probe_q;
    unique case (state_q)
      FT_OK: begin
        cnt_d = cnt_nx[COUNT_BIT-1:0];
        if (cnt_nx >= THR) begin
          state_d = FT_BROKEN;
          timer_d = '0;
        end
      end
      FT_BROKEN: begin
        if (timer_q == T_LAST) begin
          if (RECOVER != 0) begin
            state_d = FT_PROBATION;
            probe_d = '0;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      FT_PROBATION: begin
        if (err_i) begin
          state_d = FT_BROKEN;
          timer_d = '0;
        end else if (probe_q == P_LAST) begin
          state_d = FT_OK;
          cnt_d   = '0;
        end else begin
          probe_d = probe_q + 1'b1;
        end
      end
      default: state_d = FT_OK;
    endcase
    if (set_broken_i) begin
      state_d = FT_BROKEN;
      timer_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FT_OK;
      cnt_q   <= '0;
      timer_q <= '0;
      probe_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      timer_q <= timer_d;
      probe_q <= probe_d;
    end
  end

  assign state_o = state_q;

`ifdef FT_ERR_STATS_EN
  logic [15:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    if (clr_stats_i) begin
      stat_d = '0;
    end else if (err_i && (state_q != FT_BROKEN) &&
                 (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign err_count_o = stat_q;
`else
  logic unused_clr;
  assign unused_clr  = clr_stats_i;
  assign err_count_o = '0;
`endif

endmodule

// File: rtl/cv32e40p_ft_voter_monitor.sv
// TMR voter with per-replica health tracking and re-admission.
// Optional per-replica error statistics: define FT_ERR_STATS_EN.
module cv32e40p_ft_voter_monitor
  import ft_pkg::*;
#(
  parameter int unsigned NUM_CH    = FTVM_NUM_CH,
  parameter int unsigned W         = FTVM_W,
  parameter int unsigned LATENCY   = FTVM_LATENCY,
  parameter int unsigned COUNT_BIT = FTVM_COUNT_BIT,
  parameter int unsigned INCREMENT = FTVM_INCREMENT,
  parameter int unsigned DECREMENT = FTVM_DECREMENT,
  parameter int unsigned THRESHOLD = FTVM_THRESHOLD,
  parameter int unsigned RECOVER   = FTVM_RECOVER,
  parameter int unsigned HOLDOFF   = FTVM_HOLDOFF,
  parameter int unsigned PROBE_LEN = FTVM_PROBE_LEN
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [2:0][NUM_CH-1:0][W-1:0]    data_i,
  input  logic [2:0]                       set_broken_i,
  input  logic                             clr_stats_i,
  output logic [NUM_CH-1:0][W-1:0]         voted_o,
  output logic [2:0]                       is_broken_o,
  output logic                             err_detected_o,
  output logic                             err_corrected_o,
  output logic                             fatal_o,
  output logic [2:0][15:0]                 err_count_o
);

  logic [2:0][1:0] rep_state;
  logic [2:0] healthy;
  logic [2:0] err;
  logic [1:0] n_h;
  logic [NUM_CH-1:0][W-1:0] vote;
  logic det, corr, fat;

  for (genvar r = 0; r < 3; r++) begin : g_rep
    assign healthy[r] = (rep_state[r] == FT_OK);
    assign err[r]     = (data_i[r] != vote);

    cv32e40p_ft_replica_monitor #(
      .COUNT_BIT (COUNT_BIT),
      .INCREMENT (INCREMENT),
      .DECREMENT (DECREMENT),
      .THRESHOLD (THRESHOLD),
      .RECOVER   (RECOVER),
      .HOLDOFF   (HOLDOFF),
      .PROBE_LEN (PROBE_LEN)
    ) u_mon (
      .clk          (clk),
      .rst          (rst),
      .err_i        (err[r]),
      .set_broken_i (set_broken_i[r]),
      .clr_stats_i  (clr_stats_i),
      .state_o      (rep_state[r]),
      .err_count_o  (err_count_o[r])
    );
  end

  assign n_h = ft_popcnt3(healthy);

  // Replicas outside the healthy set never steer the result.
  always_comb begin
    vote = data_i[0];
    unique case (n_h)
      2'd3: vote = (data_i[0] & data_i[1]) |
                   (data_i[0] & data_i[2]) |
                   (data_i[1] & data_i[2]);
      2'd2: vote = healthy[0] ? data_i[0] : data_i[1];
      2'd1: begin
        unique case (1'b1)
          healthy[0]: vote = data_i[0];
          healthy[1]: vote = data_i[1];
          default:    vote = data_i[2];
        endcase
      end
      default: vote = data_i[0];
    endcase
  end

  assign det  = |(err & healthy);
  assign corr = det && (n_h == 2'd3);
  assign fat  = (det && (n_h == 2'd2)) || (n_h == 2'd0);

  assign is_broken_o = ~healthy;

  if (LATENCY != 0) begin : g_lat1
    logic [NUM_CH-1:0][W-1:0] voted_q;
    logic det_q, corr_q, fat_q;

    always_ff @(posedge clk) begin
      if (rst) begin
        voted_q <= '0;
        det_q   <= 1'b0;
        corr_q  <= 1'b0;
        fat_q   <= 1'b0;
      end else begin
        voted_q <= vote;
        det_q   <= det;
        corr_q  <= corr;
        fat_q   <= fat;
      end
    end

    assign voted_o         = voted_q;
    assign err_detected_o  = det_q;
    assign err_corrected_o = corr_q;
    assign fatal_o         = fat_q;
  end else begin : g_lat0
    assign voted_o         = vote;
    assign err_detected_o  = det;
    assign err_corrected_o = corr;
    assign fatal_o         = fat;
  end

endmodule

// File: tb/tb_cv32e40p_ft_voter_monitor.sv
// Self-checking bench for cv32e40p_ft_voter_monitor (default params).
// Tables, directed recovery sequences and a random run vs. a model.
module tb_cv32e40p_ft_voter_monitor;

  typedef logic [2:0][2:0][31:0] rep_t;
  typedef logic [2:0][31:0] ch_t;

  typedef struct {
    rep_t       d;
    ch_t        v;
    logic       det;
    logic       corr;
    logic       fat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clr;
  rep_t data;
  logic [2:0] sb;
  ch_t voted;
  logic [2:0] brk;
  logic det, corr, fat;
  logic [2:0][15:0] ecnt;

  always #5 clk = ~clk;

  cv32e40p_ft_voter_monitor dut (
    .clk             (clk),
    .rst             (rst),
    .data_i          (data),
    .set_broken_i    (sb),
    .clr_stats_i     (clr),
    .voted_o         (voted),
    .is_broken_o     (brk),
    .err_detected_o  (det),
    .err_corrected_o (corr),
    .fatal_o         (fat),
    .err_count_o     (ecnt)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Model state: 0 = OK, 1 = BROKEN, 2 = PROBATION.
  int st[3];
  int cnt[3];
  int tmr[3];
  int prb[3];
  int stat[3];

  ch_t e_vote;
  logic e_det, e_corr, e_fat;
  logic [2:0] e_brk, e_err;
  logic [2:0][15:0] e_cnt;

  ch_t o_vote;
  logic o_det, o_corr, o_fat;
  logic [2:0] o_brk;
  logic [2:0][15:0] o_cnt;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic rep_t rep3(input logic [31:0] a, b, c);
    rep_t t;
    for (int ch = 0; ch < 3; ch++) begin
      t[0][ch] = a;
      t[1][ch] = b;
      t[2][ch] = c;
    end
    return t;
  endfunction

  function automatic void model_reset();
    for (int r = 0; r < 3; r++) begin
      st[r] = 0; cnt[r] = 0; tmr[r] = 0; prb[r] = 0; stat[r] = 0;
    end
  endfunction

  function automatic void model_eval();
    int nh, src, ones;
    nh = 0;
    src = 0;
    for (int r = 2; r >= 0; r--)
      if (st[r] == 0) begin nh++; src = r; end
    for (int ch = 0; ch < 3; ch++)
      for (int b = 0; b < 32; b++) begin
        ones = int'(data[0][ch][b]) + int'(data[1][ch][b]) +
               int'(data[2][ch][b]);
        if (nh == 3) e_vote[ch][b] = (ones >= 2);
        else         e_vote[ch][b] = data[src][ch][b];
      end
    e_det = 1'b0;
    for (int r = 0; r < 3; r++) begin
      e_err[r] = (data[r] != e_vote);
      e_brk[r] = (st[r] != 0);
      if (st[r] == 0 && e_err[r]) e_det = 1'b1;
      e_cnt[r] = 16'(stat[r]);
    end
    e_corr = e_det && nh == 3;
    e_fat  = (e_det && nh == 2) || nh == 0;
  endfunction

  function automatic void model_update(input logic r_rst,
                                       input logic [2:0] s,
                                       input logic c);
    if (r_rst) begin
      model_reset();
      return;
    end
    for (int r = 0; r < 3; r++) begin
`ifdef FT_ERR_STATS_EN
      if (c) stat[r] = 0;
      else if (e_err[r] && st[r] != 1 && stat[r] < 65535) stat[r]++;
`endif
      if (s[r]) begin
        st[r] = 1; tmr[r] = 0;
      end else if (st[r] == 0) begin
        cnt[r] = e_err[r] ? cnt[r] + 3 : cnt[r] - 1;
        if (cnt[r] > 15) cnt[r] = 15;
        if (cnt[r] < 0) cnt[r] = 0;
        if (cnt[r] >= 8) begin st[r] = 1; tmr[r] = 0; end
      end else if (st[r] == 1) begin
        if (tmr[r] == 63) begin st[r] = 2; prb[r] = 0; end
        else tmr[r]++;
      end else begin
        if (e_err[r]) begin st[r] = 1; tmr[r] = 0; end
        else if (prb[r] == 15) begin st[r] = 0; cnt[r] = 0; end
        else prb[r]++;
      end
    end
    if (c == 1'b0) begin end
  endfunction

  task automatic step(input rep_t d, input logic [2:0] s,
                      input logic r, input logic c);
    data = d; sb = s; rst = r; clr = c;
    model_eval();
    @(negedge clk);
    o_vote = voted; o_det = det; o_corr = corr;
    o_fat = fat; o_brk = brk; o_cnt = ecnt;
    chk("voted", voted, e_vote);
    chk("err_detected", det, e_det);
    chk("err_corrected", corr, e_corr);
    chk("fatal", fat, e_fat);
    chk("is_broken", brk, e_brk);
    chk("err_count", ecnt, e_cnt);
    @(posedge clk);
    model_update(r, s, c);
    #1;
  endtask

  vec_t tab[6];
  rep_t cln, bad, dr;
  logic [31:0] w;

  initial begin
    rst = 1'b1; sb = '0; clr = 1'b0; data = '0;
    model_reset();
    cln = rep3(32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);

    step(cln, 3'b000, 1'b1, 1'b0);
    step(cln, 3'b000, 1'b1, 1'b0);
    step(cln, 3'b000, 1'b0, 1'b0);
    chk("rst_brk", o_brk, 3'b000);
    chk("rst_det", o_det, 1'b0);
    chk("rst_corr", o_corr, 1'b0);
    chk("rst_fat", o_fat, 1'b0);

    for (int k = 0; k < 100; k++) step(cln, 3'b000, 1'b0, 1'b0);
    chk("t1_vote", o_vote, {3{32'hA5A5A5A5}});

    tab[0] = '{cln, {3{32'hA5A5A5A5}}, 0, 0, 0};
    tab[1] = '{rep3(32'hA5A5A5A5, 32'hA5A5A5A4, 32'hA5A5A5A5),
               {3{32'hA5A5A5A5}}, 1, 1, 0};
    tab[2] = '{rep3(32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF),
               {3{32'hFFFFFFFF}}, 1, 1, 0};
    dr = rep3(32'h12345678, 32'h12345678, 32'h12345678);
    dr[2][1] = 32'h87654321;
    tab[3] = '{dr, {3{32'h12345678}}, 1, 1, 0};
    tab[4] = '{rep3(32'hF0, 32'hCC, 32'hAA), {3{32'hE8}}, 1, 1, 0};
    tab[5] = '{rep3(32'h0, 32'h0, 32'h0), {3{32'h0}}, 0, 0, 0};

    for (int i = 0; i < 6; i++) begin
      step(tab[i].d, 3'b000, 1'b0, 1'b0);
      chk($sformatf("tab%0d_vote", i), o_vote, tab[i].v);
      chk($sformatf("tab%0d_det", i), o_det, tab[i].det);
      chk($sformatf("tab%0d_corr", i), o_corr, tab[i].corr);
      chk($sformatf("tab%0d_fat", i), o_fat, tab[i].fat);
      for (int k = 0; k < 3; k++) step(cln, 3'b000, 1'b0, 1'b0);
      chk($sformatf("tab%0d_brk", i), o_brk, 3'b000);
    end

    // Replica 2 persistently wrong, then replica 1 too.
    step(cln, 3'b000, 1'b1, 1'b0);
    bad = rep3(32'hA5A5A5A5, 32'hA5A5A5A5, 32'h5A5A5A5A);
    for (int k = 0; k < 3; k++) step(bad, 3'b000, 1'b0, 1'b0);
    chk("t3_brk_pre", o_brk, 3'b000);
    step(rep3(32'hA5A5A5A5, 32'h11111111, 32'h5A5A5A5A),
         3'b000, 1'b0, 1'b0);
    chk("t3_brk", o_brk, 3'b100);
    chk("t3_fat", o_fat, 1'b1);
    chk("t3_det", o_det, 1'b1);
    chk("t3_corr", o_corr, 1'b0);
    chk("t3_vote", o_vote, {3{32'hA5A5A5A5}});

    // Holdoff then probation, clean data.
    step(cln, 3'b000, 1'b1, 1'b0);
    step(cln, 3'b100, 1'b0, 1'b0);
    for (int k = 1; k <= 80; k++) step(cln, 3'b000, 1'b0, 1'b0);
    chk("t4_brk_last", o_brk, 3'b100);
    step(cln, 3'b000, 1'b0, 1'b0);
    chk("t4_ok", o_brk, 3'b000);

    // Error at probe cycle 10 restarts the holdoff.
    step(cln, 3'b100, 1'b0, 1'b0);
    for (int k = 1; k <= 74; k++) step(cln, 3'b000, 1'b0, 1'b0);
    step(bad, 3'b000, 1'b0, 1'b0);
    chk("t4_probe_err_det", o_det, 1'b0);
    for (int k = 1; k <= 80; k++) step(cln, 3'b000, 1'b0, 1'b0);
    chk("t4_rst_hold", o_brk, 3'b100);
    step(cln, 3'b000, 1'b0, 1'b0);
    chk("t4_ok2", o_brk, 3'b000);

    // Forced break on the probation completion cycle.
    step(cln, 3'b001, 1'b0, 1'b0);
    for (int k = 1; k <= 79; k++) step(cln, 3'b000, 1'b0, 1'b0);
    step(cln, 3'b001, 1'b0, 1'b0);
    for (int k = 1; k <= 30; k++) begin
      if (k == 5) begin
        step(rep3(32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5),
             3'b000, 1'b0, 1'b0);
        chk("t5_vote", o_vote, {3{32'hA5A5A5A5}});
        chk("t5_det", o_det, 1'b0);
      end else begin
        step(cln, 3'b000, 1'b0, 1'b0);
      end
      chk("t5_brk", o_brk[0], 1'b1);
    end
    step(cln, 3'b000, 1'b1, 1'b0);
    step(cln, 3'b000, 1'b0, 1'b0);
    chk("t5_rst_brk", o_brk, 3'b000);
    chk("t5_rst_fat", o_fat, 1'b0);
    chk("t5_rst_det", o_det, 1'b0);

    // Randomised run against the model.
    for (int k = 0; k < 3000; k++) begin
      logic [2:0] s;
      logic r, c;
      w = $urandom;
      dr = rep3(w, w, w);
      for (int q = 0; q < 3; q++) begin
        dr[q][1] = ~w;
        dr[q][2] = w ^ 32'h0F0F00FF;
      end
      for (int q = 0; q < 3; q++)
        if ($urandom_range(0, 5) == 0)
          dr[q][$urandom_range(0, 2)][$urandom_range(0, 31)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) dr[1] = dr[2] ^ 96'h1;
      s = '0;
      if ($urandom_range(0, 199) == 0) s[$urandom_range(0, 2)] = 1'b1;
      r = ($urandom_range(0, 599) == 0);
      c = ($urandom_range(0, 49) == 0);
      step(dr, s, r, c);
    end

    step(cln, 3'b000, 1'b1, 1'b0);
    bad = rep3(32'h0, 32'hA5A5A5A5, 32'hA5A5A5A5);
    step(bad, 3'b000, 1'b0, 1'b0);
    step(bad, 3'b000, 1'b0, 1'b0);
    step(bad, 3'b000, 1'b0, 1'b1);
`ifdef FT_ERR_STATS_EN
    chk("t6_cnt_pre", o_cnt[0], 16'd2);
`else
    chk("t6_cnt_off", o_cnt, 48'h0);
`endif
    step(cln, 3'b000, 1'b0, 1'b0);
    chk("t6_cnt_clr", o_cnt[0], 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
